// File: rtl/damage_sched_pkg.sv
// Shared definitions for the damage-phase sequencer: one-hot state codes,
// army side encodings and default widths.
package damage_sched_pkg;

  localparam int NUM_UNITS_DEF = 8;
  localparam int IDX_W_DEF     = 3;
  localparam int HP_W_DEF      = 8;
  localparam int DMG_W_DEF     = 8;

  typedef logic [5:0] state_t;

  localparam state_t S_IDLE  = 6'b000001;
  localparam state_t S_SCAN  = 6'b000010;
  localparam state_t S_REQ   = 6'b000100;
  localparam state_t S_APPLY = 6'b001000;
  localparam state_t S_NEXT  = 6'b010000;
  localparam state_t S_DONE  = 6'b100000;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

endpackage

// File: rtl/damage_sched_sat_sub.sv
// Saturating HP subtract with a flag for a result that reached zero.
module sat_sub_hp #(
  parameter int HP_W  = 8,
  parameter int DMG_W = 8
) (
  input  logic [HP_W-1:0]  hp,
  input  logic [DMG_W-1:0] dmg,
  output logic [HP_W-1:0]  res,
  output logic             zero
);

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  always_comb begin
    res  = sat_sub(hp, HP_W'(dmg));
    zero = (res == '0);
  end

endmodule

// File: rtl/damage_sched.sv
// Walks every unit of both armies, requests damage for each live unit from
// the shared calculator, writes back floored HP and counts kills.
module damage_sched
  import damage_sched_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int HP_W      = HP_W_DEF,
  parameter int DMG_W     = DMG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             done,
  input  logic             ack,
  output logic             calc_req,
  output logic             calc_side,
  output logic [IDX_W-1:0] calc_idx,
  input  logic             calc_ack,
  input  logic [DMG_W-1:0] calc_dmg,
  output logic             hp_rd_side,
  output logic [IDX_W-1:0] hp_rd_idx,
  input  logic [HP_W-1:0]  hp_rd_data,
  output logic             hp_we,
  output logic             hp_wr_side,
  output logic [IDX_W-1:0] hp_wr_idx,
  output logic [HP_W-1:0]  hp_wr_data,
  output logic [IDX_W+1:0] kills,
  output logic             busy
);

  state_t             state;
  state_t             state_nx;
  logic               cur_side;
  logic [IDX_W-1:0]   cur_idx;
  logic [HP_W-1:0]    hp_q;
  logic [DMG_W-1:0]   dmg_q;
  logic [IDX_W+1:0]   kills_q;
  logic [HP_W-1:0]    sub_res;
  logic               sub_zero;
  logic               last_slot;

  assign last_slot = (cur_side == SIDE_R) && (cur_idx == IDX_W'(NUM_UNITS - 1));

  sat_sub_hp #(
    .HP_W  (HP_W),
    .DMG_W (DMG_W)
  ) u_sat_sub (
    .hp   (hp_q),
    .dmg  (dmg_q),
    .res  (sub_res),
    .zero (sub_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SCAN;
      S_SCAN:  state_nx = (hp_rd_data == '0) ? S_NEXT : S_REQ;
      S_REQ:   if (calc_ack) state_nx = S_APPLY;
      S_APPLY: state_nx = S_NEXT;
      S_NEXT:  state_nx = last_slot ? S_DONE : S_SCAN;
      S_DONE:  if (ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Cursor, latched operands and kill counter advance alongside the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_side <= SIDE_L;
      cur_idx  <= '0;
      hp_q     <= '0;
      dmg_q    <= '0;
      kills_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cur_side <= SIDE_L;
          cur_idx  <= '0;
          kills_q  <= '0;
        end
        S_SCAN:  if (hp_rd_data != '0) hp_q <= hp_rd_data;
        S_REQ:   if (calc_ack) dmg_q <= calc_dmg;
        S_APPLY: if (sub_zero) kills_q <= kills_q + (IDX_W+2)'(1);
        S_NEXT: if (!last_slot) begin
          if (cur_idx == IDX_W'(NUM_UNITS - 1)) cur_side <= SIDE_R;
          cur_idx <= cur_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done       = (state == S_DONE);
    busy       = (state != S_IDLE) && (state != S_DONE);
    calc_req   = (state == S_REQ);
    hp_we      = (state == S_APPLY);
    hp_wr_data = hp_we ? sub_res : '0;
  end

  assign calc_side  = cur_side;
  assign calc_idx   = cur_idx;
  assign hp_rd_side = cur_side;
  assign hp_rd_idx  = cur_idx;
  assign hp_wr_side = cur_side;
  assign hp_wr_idx  = cur_idx;
  assign kills      = kills_q;

endmodule

// File: tb/tb_damage_sched.sv
// Directed bench for damage_sched: HP register file and calculator models
// with a programmable acknowledge delay.
module tb_damage_sched;

  localparam int NUM_UNITS = 8;
  localparam int IDX_W     = 3;
  localparam int HP_W      = 8;
  localparam int DMG_W     = 8;
  localparam int LOG_W     = 1 + IDX_W + HP_W;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             done;
  logic             ack;
  logic             calc_req;
  logic             calc_side;
  logic [IDX_W-1:0] calc_idx;
  logic             calc_ack;
  logic [DMG_W-1:0] calc_dmg;
  logic             hp_rd_side;
  logic [IDX_W-1:0] hp_rd_idx;
  logic [HP_W-1:0]  hp_rd_data;
  logic             hp_we;
  logic             hp_wr_side;
  logic [IDX_W-1:0] hp_wr_idx;
  logic [HP_W-1:0]  hp_wr_data;
  logic [IDX_W+1:0] kills;
  logic             busy;

  int total = 0;
  int bad   = 0;

  logic [HP_W-1:0]  hp_mem  [2][NUM_UNITS];
  logic [HP_W-1:0]  hp_load [2][NUM_UNITS];
  logic [DMG_W-1:0] dmg_tab [2][NUM_UNITS];
  logic             do_load;
  logic [LOG_W-1:0] wr_log [256];
  int               wr_cnt;
  int               calc_wait;
  int               wcnt;

  damage_sched #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (IDX_W),
    .HP_W      (HP_W),
    .DMG_W     (DMG_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .done       (done),
    .ack        (ack),
    .calc_req   (calc_req),
    .calc_side  (calc_side),
    .calc_idx   (calc_idx),
    .calc_ack   (calc_ack),
    .calc_dmg   (calc_dmg),
    .hp_rd_side (hp_rd_side),
    .hp_rd_idx  (hp_rd_idx),
    .hp_rd_data (hp_rd_data),
    .hp_we      (hp_we),
    .hp_wr_side (hp_wr_side),
    .hp_wr_idx  (hp_wr_idx),
    .hp_wr_data (hp_wr_data),
    .kills      (kills),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hp_rd_data = hp_mem[hp_rd_side][hp_rd_idx];
  assign calc_dmg   = dmg_tab[calc_side][calc_idx];
  assign calc_ack   = calc_req && (wcnt == calc_wait);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 wcnt <= 0;
    else if (calc_req && !calc_ack) wcnt <= wcnt + 1;
    else                          wcnt <= 0;
  end

  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (do_load) hp_mem <= hp_load;
    else if (hp_we) begin
      hp_mem[hp_wr_side][hp_wr_idx] <= hp_wr_data;
      wr_log[wr_cnt] <= {hp_wr_side, hp_wr_idx, hp_wr_data};
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int hp, input int dmg);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NUM_UNITS; i++) begin
        hp_load[s][i] = HP_W'(hp);
        dmg_tab[s][i] = DMG_W'(dmg);
      end
  endtask

  task automatic load_mem();
    @(negedge clk); do_load = 1'b1;
    @(posedge clk); #1 do_load = 1'b0;
  endtask

  // Returns edges from the start-sampling edge until done is seen (SCAN->DONE = n-1).
  task automatic run_pass(input bit poke, output int n, output int unstable);
    logic             pend;
    logic [IDX_W:0]   paddr;
    n = 0; unstable = 0; pend = 1'b0; paddr = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    n = 1;
    while (!done && n < 2000) begin
      if (pend && calc_req && ({calc_side, calc_idx} != paddr)) unstable++;
      pend  = calc_req && !calc_ack;
      paddr = {calc_side, calc_idx};
      if (poke && n == 10) begin start = 1'b1; ack = 1'b1; end
      else                 begin start = 1'b0; ack = 1'b0; end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; ack = 1'b0;
    check("pass_reaches_done", int'(done), 1);
  endtask

  task automatic check_writes(input string tag, input int base, input int exp_cnt,
                              input logic [1:0][NUM_UNITS-1:0] live,
                              input logic [HP_W-1:0] exp_hp [2][NUM_UNITS]);
    int k;
    logic [LOG_W-1:0] exp_e;
    k = base;
    check({tag, "_write_count"}, wr_cnt - base, exp_cnt);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NUM_UNITS; i++)
        if (live[s][i]) begin
          exp_e = {s[0], IDX_W'(i), exp_hp[s][i]};
          check($sformatf("%s_wr_%0d_%0d", tag, s, i), int'(wr_log[k]), int'(exp_e));
          k++;
        end
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  logic [HP_W-1:0]          exp_hp [2][NUM_UNITS];
  logic [1:0][NUM_UNITS-1:0] live;
  int n, unstable, base, guard;

  initial begin
    reset_n = 1'b0; start = 1'b0; ack = 1'b0; do_load = 1'b0; calc_wait = 0;
    set_all(50, 10);
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_calc_req", int'(calc_req), 0);
    check("rst_hp_we", int'(hp_we), 0);
    check("rst_kills", int'(kills), 0);
    check("rst_cursor", int'({calc_side, calc_idx}), 0);
    check("rst_wr_data", int'(hp_wr_data), 0);
    @(negedge clk); reset_n = 1'b1;
    load_mem();

    // Pass 1: all live at 50, damage 10, zero-wait.
    live = '1;
    for (int s = 0; s < 2; s++) for (int i = 0; i < NUM_UNITS; i++) exp_hp[s][i] = 8'd40;
    base = wr_cnt;
    run_pass(1'b0, n, unstable);
    check("p1_cycles", n - 1, 64);
    check_writes("p1", base, 16, live, exp_hp);
    check("p1_kills", int'(kills), 0);
    check("p1_busy_in_done", int'(busy), 0);
    @(posedge clk); #1;
    check("p1_done_held", int'(done), 1);
    // ack and start together: ack wins, start dropped.
    @(negedge clk); ack = 1'b1; start = 1'b1;
    @(posedge clk); #1 ack = 1'b0; start = 1'b0;
    check("ack_start_done", int'(done), 0);
    @(posedge clk); #1;
    check("ack_start_not_busy", int'(busy), 0);

    // Pass 2: one unit saturates to zero; start/ack poked mid-pass.
    hp_load = hp_mem;
    hp_load[1][3] = 8'd5;
    load_mem();
    dmg_tab[1][3] = 8'd9;
    for (int s = 0; s < 2; s++) for (int i = 0; i < NUM_UNITS; i++) exp_hp[s][i] = 8'd30;
    exp_hp[1][3] = 8'd0;
    base = wr_cnt;
    run_pass(1'b1, n, unstable);
    check("p2_cycles", n - 1, 64);
    check_writes("p2", base, 16, live, exp_hp);
    check("p2_kills", int'(kills), 1);
    do_ack();
    check("p2_ack_done", int'(done), 0);
    check("p2_kills_retained", int'(kills), 1);

    // Pass 3: side0 idx 2 and 5 dead.
    set_all(50, 10);
    hp_load[0][2] = 8'd0;
    hp_load[0][5] = 8'd0;
    load_mem();
    live = '1; live[0][2] = 1'b0; live[0][5] = 1'b0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < NUM_UNITS; i++) exp_hp[s][i] = 8'd40;
    base = wr_cnt;
    run_pass(1'b0, n, unstable);
    check("p3_cycles", n - 1, 60);
    check_writes("p3", base, 14, live, exp_hp);
    check("p3_kills_cleared", int'(kills), 0);
    do_ack();

    // Pass 4: calculator acks after 3 wait cycles.
    set_all(50, 10);
    load_mem();
    calc_wait = 3;
    live = '1;
    base = wr_cnt;
    run_pass(1'b0, n, unstable);
    check("p4_cycles", n - 1, 112);
    check("p4_req_stable", unstable, 0);
    check_writes("p4", base, 16, live, exp_hp);
    do_ack();

    // Reset while waiting in REQ at (1,4).
    set_all(50, 10);
    hp_load[0][0] = 8'd5;
    load_mem();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    guard = 0;
    while (!(calc_req && calc_side && calc_idx == 3'd4) && guard < 500) begin
      @(posedge clk); #1; guard++;
    end
    check("rr_reached_req_1_4", int'(calc_req && calc_side && calc_idx == 3'd4), 1);
    check("rr_kills_before", int'(kills), 1);
    reset_n = 1'b0;
    #1;
    check("rr_calc_req", int'(calc_req), 0);
    check("rr_busy", int'(busy), 0);
    check("rr_done", int'(done), 0);
    check("rr_hp_we", int'(hp_we), 0);
    check("rr_kills", int'(kills), 0);
    check("rr_cursor", int'({calc_side, calc_idx}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    calc_wait = 0;
    set_all(50, 10);
    load_mem();
    base = wr_cnt;
    run_pass(1'b0, n, unstable);
    check("rr_restart_cycles", n - 1, 64);
    check("rr_first_write", int'(wr_log[base]), int'({1'b0, 3'd0, 8'd40}));
    check("rr_restart_kills", int'(kills), 0);
    do_ack();
    check("rr_final_done", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
